i2c_config_sequencer: RTL

- Walks a configuration table of register writes for one I2C sensor device.
- Issues each write through the single-register I2C write engine (start / done / message_failure handshake).
- Handles retries, per-write timeouts and delay entries.
- Sits between the top-level sensor bring-up logic and the write engine. It is the only driver of the engine's start and data inputs.

---
 rtl/i2c_config_sequencer.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/i2c_config_sequencer.sv
// Walks a register-write table for one I2C sensor and drives the single-register
// write engine, with per-entry retries, write timeouts and delay entries.
module i2c_config_sequencer #(
    parameter logic [6:0] DEV_ADDRESS = 7'h21,
    parameter int TABLE_AW    = 6,
    parameter int MAX_RETRIES = 3,
    parameter int WR_TIMEOUT  = 100000,
    parameter int DELAY_UNIT  = 25000,
    parameter int RETRY_GAP   = 1000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                go,
    input  logic                abort,
    output logic [TABLE_AW-1:0] table_addr,
    input  logic [15:0]         table_entry,
    output logic                wr_start,
    output logic [6:0]          wr_dev_address,
    output logic [7:0]          wr_reg_address,
    output logic [7:0]          wr_data,
    input  logic                wr_done,
    input  logic                wr_failure,
    output logic                busy,
    output logic                config_done,
    output logic                config_error,
    output logic [TABLE_AW-1:0] error_index,
    output logic [2:0]          retry_count,
    output logic [3:0]          state_out
);
    localparam int DW       = 8 + $clog2(DELAY_UNIT);
    localparam int TW       = $clog2(WR_TIMEOUT + 1);
    localparam int GAP_LOAD = (RETRY_GAP > 0) ? RETRY_GAP - 1 : 0;
    localparam int GW       = (GAP_LOAD > 0) ? $clog2(GAP_LOAD + 1) : 1;

    typedef enum logic [3:0] {
        IDLE        = 4'd0,
        FETCH       = 4'd1,
        DECODE      = 4'd2,
        WRITE_START = 4'd3,
        WRITE_WAIT  = 4'd4,
        RETRY_WAIT  = 4'd5,
        DELAY       = 4'd6,
        DONE        = 4'd7,
        ERROR       = 4'd8
    } state_t;

    state_t        state, next_state;
    logic [DW-1:0] dly_cnt;
    logic [TW-1:0] tmo_cnt;
    logic [GW-1:0] gap_cnt;
    logic          done_q;
    logic          done_rise, tmo_hit;
    logic          start_pass, latch_wr, load_delay, inc_addr, retry, set_err, set_done, clr_retry, adv;

    assign done_rise      = wr_done & ~done_q;
    assign tmo_hit        = (tmo_cnt == TW'(WR_TIMEOUT));
    assign wr_start       = (state == WRITE_START) && !abort;
    assign wr_dev_address = DEV_ADDRESS;
    assign busy           = !(state inside {IDLE, DONE, ERROR});
    assign state_out      = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        start_pass = 1'b0;
        latch_wr   = 1'b0;
        load_delay = 1'b0;
        inc_addr   = 1'b0;
        retry      = 1'b0;
        set_err    = 1'b0;
        set_done   = 1'b0;
        clr_retry  = 1'b0;
        adv        = 1'b0;
        unique case (state)
            IDLE, DONE, ERROR: if (go) begin
                start_pass = 1'b1;
                next_state = FETCH;
            end
            FETCH: next_state = DECODE;
            DECODE: begin
                if (table_entry == 16'hFFFF) begin
                    set_done   = 1'b1;
                    next_state = DONE;
                end else if (table_entry[15:8] == 8'hFE) begin
                    load_delay = 1'b1;
                    next_state = DELAY;
                end else begin
                    latch_wr   = 1'b1;
                    next_state = WRITE_START;
                end
            end
            WRITE_START: next_state = WRITE_WAIT;
            // failure wins over a coincident done edge
            WRITE_WAIT: begin
                if (wr_failure || tmo_hit) begin
                    if (retry_count < 3'(MAX_RETRIES)) begin
                        retry      = 1'b1;
                        next_state = RETRY_WAIT;
                    end else begin
                        set_err    = 1'b1;
                        next_state = ERROR;
                    end
                end else if (done_rise) begin
                    clr_retry = 1'b1;
                    adv       = 1'b1;
                end
            end
            RETRY_WAIT: if (gap_cnt == '0) next_state = WRITE_START;
            DELAY:      if (dly_cnt <= DW'(1)) adv = 1'b1;
            default:    next_state = IDLE;
        endcase
        if (adv) begin
            if (&table_addr) begin
                set_err    = 1'b1;
                next_state = ERROR;
            end else begin
                inc_addr   = 1'b1;
                next_state = FETCH;
            end
        end
        if (abort) next_state = IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            table_addr     <= '0;
            wr_reg_address <= '0;
            wr_data        <= '0;
            config_done    <= 1'b0;
            config_error   <= 1'b0;
            error_index    <= '0;
            retry_count    <= '0;
            dly_cnt        <= '0;
            tmo_cnt        <= '0;
            gap_cnt        <= '0;
            done_q         <= 1'b0;
        end else begin
            done_q <= wr_done;
            if (state == WRITE_START)                 tmo_cnt <= '0;
            else if (state == WRITE_WAIT && !tmo_hit) tmo_cnt <= tmo_cnt + TW'(1);
            if (load_delay)                           dly_cnt <= DW'(table_entry[7:0]) * DW'(DELAY_UNIT);
            else if (state == DELAY && dly_cnt != '0) dly_cnt <= dly_cnt - DW'(1);
            if (retry)                                     gap_cnt <= GW'(GAP_LOAD);
            else if (state == RETRY_WAIT && gap_cnt != '0) gap_cnt <= gap_cnt - GW'(1);
            if (abort) begin
                config_done  <= 1'b0;
                config_error <= 1'b0;
            end else begin
                if (start_pass) begin
                    table_addr   <= '0;
                    retry_count  <= '0;
                    config_done  <= 1'b0;
                    config_error <= 1'b0;
                end
                if (latch_wr) {wr_reg_address, wr_data} <= table_entry;
                if (inc_addr) table_addr <= table_addr + TABLE_AW'(1);
                if (retry)     retry_count <= retry_count + 3'd1;
                if (clr_retry) retry_count <= '0;
                if (set_err) begin
                    error_index  <= table_addr;
                    config_error <= 1'b1;
                end
                if (set_done) config_done <= 1'b1;
            end
        end
    end
endmodule
